// File: rtl/rv32_branch_pkg.sv
// Shared encodings for the execute-stage branch resolver:
// B-type funct3 values and the resolver FSM states.
package rv32_branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } br_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the ID/EX register, the branch resolver and the fetch PC mux.
// The pipeline/fetch side uses master, the resolver uses slave.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             i_br_valid;
    logic             o_br_ready;
    logic [2:0]       i_br_funct3;
    logic             i_br_is_jal;
    logic             i_br_is_jalr;
    logic [XLEN-1:0]  i_br_pc;
    logic [XLEN-1:0]  i_rs1;
    logic [XLEN-1:0]  i_rs2;
    logic [XLEN-1:0]  i_br_imm;
    logic             i_pred_taken;
    logic [XLEN-1:0]  i_pred_target;
    logic             i_kill;
    logic             o_res_valid;
    logic             o_res_taken;
    logic [XLEN-1:0]  o_res_target;
    logic             o_flush;
    logic             o_redir_valid;
    logic             i_redir_ready;
    logic [XLEN-1:0]  o_redir_pc;
    logic             o_illegal;
    logic             o_misalign;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_mispred_cnt;

    modport master (
        output i_br_valid, i_br_funct3, i_br_is_jal, i_br_is_jalr, i_br_pc,
               i_rs1, i_rs2, i_br_imm, i_pred_taken, i_pred_target, i_kill,
               i_redir_ready,
        input  o_br_ready, o_res_valid, o_res_taken, o_res_target, o_flush,
               o_redir_valid, o_redir_pc, o_illegal, o_misalign, o_br_cnt,
               o_mispred_cnt
    );

    modport slave (
        input  i_br_valid, i_br_funct3, i_br_is_jal, i_br_is_jalr, i_br_pc,
               i_rs1, i_rs2, i_br_imm, i_pred_taken, i_pred_target, i_kill,
               i_redir_ready,
        output o_br_ready, o_res_valid, o_res_taken, o_res_target, o_flush,
               o_redir_valid, o_redir_pc, o_illegal, o_misalign, o_br_cnt,
               o_mispred_cnt
    );

endinterface

// File: rtl/comparator_32bit.sv
// 32-bit magnitude comparator; signed mode biases both MSBs so a single
// unsigned compare serves both interpretations.
module comparator_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_unsigned,
    output logic        equal,
    output logic        larger,
    output logic        smaller
);
    logic [31:0] a_k;
    logic [31:0] b_k;

    assign a_k     = {a[31] ^ ~is_unsigned, a[30:0]};
    assign b_k     = {b[31] ^ ~is_unsigned, b[30:0]};
    assign equal   = (a == b);
    assign larger  = (a_k > b_k);
    assign smaller = (a_k < b_k);

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: registers one micro-op, resolves it in
// a dedicated cycle and raises flush plus a held redirect on mispredict.
//
// state    | meaning
// IDLE     | ready for a new micro-op
// EVAL     | operands registered, direction/target resolved this cycle
// REDIRECT | mispredict redirect held until fetch accepts it
module branch_resolve_unit
    import rv32_branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam logic [XLEN-1:0] JALR_MASK  = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

    br_state_e state_q, state_d;

    logic [2:0]      funct3_q;
    logic            is_jal_q, is_jalr_q, pred_taken_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, pred_target_q;

    logic            res_valid_q, res_taken_q, flush_q, redir_valid_q;
    logic            illegal_q, misalign_q;
    logic [XLEN-1:0] res_target_q, redir_pc_q;
    logic [CNT_W-1:0] br_cnt_q, mispred_cnt_q;

    logic            equal, larger, smaller;
    logic            cond_taken, bad_funct3, is_jump;
    logic            taken_c, illegal_c, misalign_c, mispred_c;
    logic [XLEN-1:0] tgt_c, next_pc_c;
    logic            accept, eval_done, redir_done;

    comparator_32bit u_cmp (
        .a           (rs1_q),
        .b           (rs2_q),
        .is_unsigned (funct3_q[1]),
        .equal       (equal),
        .larger      (larger),
        .smaller     (smaller)
    );

    always_comb begin
        cond_taken = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3_q)
            BEQ:        cond_taken = equal;
            BNE:        cond_taken = !equal;
            BLT, BLTU:  cond_taken = smaller;
            BGE, BGEU:  cond_taken = larger || equal;
            default:    bad_funct3 = 1'b1;
        endcase
    end

    assign is_jump    = is_jal_q || is_jalr_q;
    assign taken_c    = is_jump || cond_taken;
    assign illegal_c  = !is_jump && bad_funct3;
    assign tgt_c      = is_jalr_q ? ((rs1_q + imm_q) & JALR_MASK) : (pc_q + imm_q);
    assign next_pc_c  = taken_c ? tgt_c : (pc_q + INSN_BYTES);
    assign misalign_c = taken_c && (tgt_c[1:0] != 2'b00);
    // Illegal and misaligned ops trap elsewhere, so they never redirect fetch.
    assign mispred_c  = !illegal_c && !misalign_c &&
                        ((taken_c != pred_taken_q) || (taken_c && (tgt_c != pred_target_q)));

    assign accept     = bus.i_br_valid && (state_q == IDLE) && !bus.i_kill;
    assign eval_done  = (state_q == EVAL) && !bus.i_kill;
    assign redir_done = (state_q == REDIRECT) && (bus.i_kill || bus.i_redir_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = EVAL;
            EVAL:     if (bus.i_kill)     state_d = IDLE;
                      else if (mispred_c) state_d = REDIRECT;
                      else                state_d = IDLE;
            REDIRECT: if (redir_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            funct3_q      <= '0;
            is_jal_q      <= 1'b0;
            is_jalr_q     <= 1'b0;
            pc_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else if (accept) begin
            funct3_q      <= bus.i_br_funct3;
            is_jal_q      <= bus.i_br_is_jal;
            is_jalr_q     <= bus.i_br_is_jalr;
            pc_q          <= bus.i_br_pc;
            rs1_q         <= bus.i_rs1;
            rs2_q         <= bus.i_rs2;
            imm_q         <= bus.i_br_imm;
            pred_taken_q  <= bus.i_pred_taken;
            pred_target_q <= bus.i_pred_target;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_valid_q   <= 1'b0;
            res_taken_q   <= 1'b0;
            res_target_q  <= '0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            illegal_q     <= 1'b0;
            misalign_q    <= 1'b0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            res_valid_q <= 1'b0;
            flush_q     <= 1'b0;
            illegal_q   <= 1'b0;
            misalign_q  <= 1'b0;
            if (eval_done) begin
                res_valid_q  <= 1'b1;
                res_taken_q  <= taken_c;
                res_target_q <= next_pc_c;
                illegal_q    <= illegal_c;
                misalign_q   <= misalign_c;
                if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_W'(1);
                if (mispred_c) begin
                    flush_q       <= 1'b1;
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= next_pc_c;
                    if (mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
                end
            end
            if (redir_done) redir_valid_q <= 1'b0;
        end
    end

    assign bus.o_br_ready    = (state_q == IDLE);
    assign bus.o_res_valid   = res_valid_q;
    assign bus.o_res_taken   = res_taken_q;
    assign bus.o_res_target  = res_target_q;
    assign bus.o_flush       = flush_q;
    assign bus.o_redir_valid = redir_valid_q;
    assign bus.o_redir_pc    = redir_pc_q;
    assign bus.o_illegal     = illegal_q;
    assign bus.o_misalign    = misalign_q;
    assign bus.o_br_cnt      = br_cnt_q;
    assign bus.o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus random bench for branch_resolve_unit; expectations come from
// a behavioural branch model using plain signed/unsigned arithmetic.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   br_cnt_m  = 0;
    int   mis_cnt_m = 0;

    typedef struct packed {
        logic [2:0]  f3;
        logic        jal;
        logic        jalr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        pt;
        logic [31:0] ptgt;
    } op_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] next;
        logic        illegal;
        logic        misalign;
        logic        mispred;
    } exp_t;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bus ();

    branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input op_t op);
        exp_t e;
        e = '0;
        if (op.jalr) begin
            e.taken = 1'b1;
            e.tgt   = (op.rs1 + op.imm) & 32'hFFFF_FFFE;
        end else if (op.jal) begin
            e.taken = 1'b1;
            e.tgt   = op.pc + op.imm;
        end else begin
            e.tgt = op.pc + op.imm;
            case (op.f3)
                3'd0: e.taken = (op.rs1 == op.rs2);
                3'd1: e.taken = (op.rs1 != op.rs2);
                3'd4: e.taken = ($signed(op.rs1) <  $signed(op.rs2));
                3'd5: e.taken = ($signed(op.rs1) >= $signed(op.rs2));
                3'd6: e.taken = (op.rs1 <  op.rs2);
                3'd7: e.taken = (op.rs1 >= op.rs2);
                default: begin
                    e.taken   = 1'b0;
                    e.illegal = 1'b1;
                end
            endcase
        end
        e.next     = e.taken ? e.tgt : op.pc + 32'd4;
        e.misalign = e.taken && (e.tgt % 4 != 0);
        e.mispred  = !e.illegal && !e.misalign &&
                     ((e.taken != op.pt) || (e.taken && e.tgt != op.ptgt));
        return e;
    endfunction

    function automatic op_t mk(input logic [2:0] f3, input logic jal, input logic jalr,
                               input logic [31:0] pc, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm,
                               input logic pt, input logic [31:0] ptgt);
        op_t op;
        op.f3 = f3; op.jal = jal; op.jalr = jalr; op.pc = pc; op.rs1 = rs1;
        op.rs2 = rs2; op.imm = imm; op.pt = pt; op.ptgt = ptgt;
        return op;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_br_valid    = 1'b0;
        bus.i_br_funct3   = '0;
        bus.i_br_is_jal   = 1'b0;
        bus.i_br_is_jalr  = 1'b0;
        bus.i_br_pc       = '0;
        bus.i_rs1         = '0;
        bus.i_rs2         = '0;
        bus.i_br_imm      = '0;
        bus.i_pred_taken  = 1'b0;
        bus.i_pred_target = '0;
        bus.i_kill        = 1'b0;
        bus.i_redir_ready = 1'b0;
    endtask

    task automatic drive(input op_t op);
        bus.i_br_funct3   = op.f3;
        bus.i_br_is_jal   = op.jal;
        bus.i_br_is_jalr  = op.jalr;
        bus.i_br_pc       = op.pc;
        bus.i_rs1         = op.rs1;
        bus.i_rs2         = op.rs2;
        bus.i_br_imm      = op.imm;
        bus.i_pred_taken  = op.pt;
        bus.i_pred_target = op.ptgt;
        bus.i_br_valid    = 1'b1;
    endtask

    // Issue one op and check its capture, resolution and redirect phase.
    task automatic run_op(input op_t op, input int hold, input string tag);
        exp_t e;
        logic [31:0] rpc;
        e = model(op);
        chk({tag, "/ready_idle"}, bus.o_br_ready, 1);
        drive(op);
        tick();
        bus.i_br_valid = 1'b0;
        chk({tag, "/ready_busy"}, bus.o_br_ready, 0);
        chk({tag, "/res_early"}, bus.o_res_valid, 0);
        tick();
        br_cnt_m = sat16(br_cnt_m + 1);
        if (e.mispred) mis_cnt_m = sat16(mis_cnt_m + 1);
        chk({tag, "/res_valid"}, bus.o_res_valid, 1);
        chk({tag, "/res_taken"}, bus.o_res_taken, e.taken);
        chk({tag, "/res_target"}, bus.o_res_target, e.next);
        chk({tag, "/flush"}, bus.o_flush, e.mispred);
        chk({tag, "/illegal"}, bus.o_illegal, e.illegal);
        chk({tag, "/misalign"}, bus.o_misalign, e.misalign);
        chk({tag, "/redir_valid"}, bus.o_redir_valid, e.mispred);
        chk({tag, "/br_cnt"}, bus.o_br_cnt, br_cnt_m);
        chk({tag, "/mispred_cnt"}, bus.o_mispred_cnt, mis_cnt_m);
        if (e.mispred) begin
            rpc = e.next;
            chk({tag, "/redir_pc"}, bus.o_redir_pc, rpc);
            for (int i = 0; i < hold; i++) begin
                tick();
                chk({tag, "/hold_valid"}, bus.o_redir_valid, 1);
                chk({tag, "/hold_pc"}, bus.o_redir_pc, rpc);
                chk({tag, "/hold_ready"}, bus.o_br_ready, 0);
                chk({tag, "/hold_flush"}, bus.o_flush, 0);
                chk({tag, "/hold_res"}, bus.o_res_valid, 0);
            end
            bus.i_redir_ready = 1'b1;
            tick();
            bus.i_redir_ready = 1'b0;
            chk({tag, "/redir_drop"}, bus.o_redir_valid, 0);
            chk({tag, "/ready_back"}, bus.o_br_ready, 1);
        end else begin
            chk({tag, "/ready_after"}, bus.o_br_ready, 1);
            tick();
            chk({tag, "/res_pulse"}, bus.o_res_valid, 0);
        end
    endtask

    initial begin
        op_t  op;
        exp_t e;

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/ready", bus.o_br_ready, 1);
        chk("rst/res_valid", bus.o_res_valid, 0);
        chk("rst/res_taken", bus.o_res_taken, 0);
        chk("rst/res_target", bus.o_res_target, 0);
        chk("rst/flush", bus.o_flush, 0);
        chk("rst/redir_valid", bus.o_redir_valid, 0);
        chk("rst/redir_pc", bus.o_redir_pc, 0);
        chk("rst/illegal", bus.o_illegal, 0);
        chk("rst/misalign", bus.o_misalign, 0);
        chk("rst/br_cnt", bus.o_br_cnt, 0);
        chk("rst/mispred_cnt", bus.o_mispred_cnt, 0);
        rst_n = 1'b1;
        tick();

        run_op(mk(3'b000, 1'b0, 1'b1, 32'h300, 32'h203, 32'h0, 32'h0, 1'b1, 32'h202), 0, "jalr");
        run_op(mk(3'b000, 1'b0, 1'b0, 32'h100, 32'h1234, 32'h1234, 32'h20, 1'b0, 32'h0), 0, "beq");
        run_op(mk(3'b100, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0, 32'h0), 5, "blt");
        run_op(mk(3'b110, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0, 32'h0), 0, "bltu");
        run_op(mk(3'b010, 1'b0, 1'b0, 32'h400, 32'h5, 32'h5, 32'h10, 1'b1, 32'h410), 0, "illegal");
        run_op(mk(3'b000, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h2, 1'b0, 32'h0), 0, "jal_mis");
        run_op(mk(3'b001, 1'b0, 1'b0, 32'h500, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1, 32'h4F0), 0, "bne_ok");
        run_op(mk(3'b001, 1'b0, 1'b0, 32'h500, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1, 32'h4F4), 2, "bne_tgt");
        run_op(mk(3'b000, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 1'b1, 32'h4), 0, "jal_wrap");
        run_op(mk(3'b101, 1'b0, 1'b0, 32'h600, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8, 1'b1, 32'h608), 1, "bge");

        // Kill while a redirect is pending, with fetch ready in the same cycle.
        op = mk(3'b000, 1'b0, 1'b0, 32'h700, 32'h9, 32'h9, 32'h30, 1'b0, 32'h0);
        drive(op);
        tick();
        bus.i_br_valid = 1'b0;
        tick();
        br_cnt_m++;
        mis_cnt_m++;
        chk("kill_redir/valid_up", bus.o_redir_valid, 1);
        bus.i_kill = 1'b1;
        bus.i_redir_ready = 1'b1;
        tick();
        bus.i_kill = 1'b0;
        bus.i_redir_ready = 1'b0;
        chk("kill_redir/valid_drop", bus.o_redir_valid, 0);
        chk("kill_redir/ready", bus.o_br_ready, 1);
        tick();
        chk("kill_redir/br_cnt", bus.o_br_cnt, br_cnt_m);
        chk("kill_redir/mispred_cnt", bus.o_mispred_cnt, mis_cnt_m);

        // Kill during evaluation suppresses every pulse and counter update.
        drive(op);
        tick();
        bus.i_br_valid = 1'b0;
        bus.i_kill = 1'b1;
        tick();
        bus.i_kill = 1'b0;
        chk("kill_eval/res_valid", bus.o_res_valid, 0);
        chk("kill_eval/flush", bus.o_flush, 0);
        chk("kill_eval/redir_valid", bus.o_redir_valid, 0);
        chk("kill_eval/ready", bus.o_br_ready, 1);
        chk("kill_eval/br_cnt", bus.o_br_cnt, br_cnt_m);
        chk("kill_eval/mispred_cnt", bus.o_mispred_cnt, mis_cnt_m);

        // Kill in IDLE blocks acceptance of the presented op.
        drive(op);
        bus.i_kill = 1'b1;
        tick();
        bus.i_br_valid = 1'b0;
        bus.i_kill = 1'b0;
        chk("kill_idle/ready", bus.o_br_ready, 1);
        tick();
        chk("kill_idle/res_valid", bus.o_res_valid, 0);
        chk("kill_idle/br_cnt", bus.o_br_cnt, br_cnt_m);

        // Asynchronous reset in the middle of a held redirect.
        drive(op);
        tick();
        bus.i_br_valid = 1'b0;
        tick();
        chk("arst/valid_up", bus.o_redir_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst/redir_valid", bus.o_redir_valid, 0);
        chk("arst/ready", bus.o_br_ready, 1);
        chk("arst/br_cnt", bus.o_br_cnt, 0);
        chk("arst/mispred_cnt", bus.o_mispred_cnt, 0);
        br_cnt_m = 0;
        mis_cnt_m = 0;
        #2;
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 40; n++) begin
            op.f3   = 3'($urandom_range(0, 7));
            op.jalr = ($urandom_range(0, 7) == 0);
            op.jal  = ($urandom_range(0, 7) == 0);
            op.pc   = $urandom() & 32'hFFFF_FFFC;
            op.rs1  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) - 32'd3 : $urandom();
            op.rs2  = ($urandom_range(0, 3) == 0) ? op.rs1 : 32'($urandom_range(0, 7)) - 32'd3;
            op.imm  = ($urandom_range(0, 3) == 0) ? $urandom() : (32'($urandom_range(0, 64)) - 32'd32) & 32'hFFFF_FFFC;
            op.pt   = 1'($urandom_range(0, 1));
            op.ptgt = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 0) begin
                e = model(op);
                op.pt   = e.taken;
                op.ptgt = ($urandom_range(0, 3) == 0) ? e.tgt + 32'd4 : e.tgt;
            end
            run_op(op, int'($urandom_range(0, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
